ofm_maxpool_2x2: RTL and testbench
==================================

// Module: ofm_maxpool_2x2
// PURPOSE
//  Downstream stage of the convolution engine. Consumes its serial 13-bit OFM stream
//  (row-major, one pixel per valid cycle) and performs 2x2/stride-2 max pooling using
//  a half-row line buffer. Emits one pooled pixel per completed 2x2 window and flags
//  end-of-frame for the next layer or the output collector.
// PARAMETERS
//  DATA_W  13  pixel width, equal to the convolution engine output width
//  OFM_W   8   OFM row width in pixels; must be even and >= 2
//  OFM_H   8   OFM rows per frame; must be even and >= 2
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            synchronous reset, active-high
//  in_valid    in   1            OFM pixel valid; driven by the conv out_valid
//  In_OFM      in   DATA_W       OFM pixel, unsigned
//  out_valid   out  1            pooled pixel valid
//  Out_Pool    out  DATA_W       pooled pixel, unsigned
//  frame_done  out  1            1-cycle pulse coincident with the last pooled pixel of a frame
// BEHAVIOUR
//  - Reset: out_valid=0, Out_Pool=0, frame_done=0, col=0, row=0, prev=0.
//    Line-buffer contents are don't-care after reset; they are always written before being read.
//  - Counters:
//    - col (0..OFM_W-1) and row (0..OFM_H-1) advance only on in_valid.
//    - col wraps to 0 and row increments at col==OFM_W-1.
//    - row wraps to 0 after the pixel at (OFM_H-1, OFM_W-1).
//    - in_valid gaps of any length are legal and do not change position or state.
//  - Even col: prev <= In_OFM.
//  - Odd col: hmax = max(prev, In_OFM).
//    - Even row: lb[col>>1] <= hmax. The line buffer has OFM_W/2 entries of DATA_W bits.
//    - Odd row: result = max(lb[col>>1], hmax).
//  - Output timing: out_valid=1 and Out_Pool=result in the cycle after the accepting edge
//    of an odd-row/odd-col pixel. Fixed latency is 1 clk.
//    - In every other cycle, out_valid=0 and Out_Pool=0.
//  - Output count: each frame yields exactly (OFM_W/2)*(OFM_H/2) pooled pixels, in row-major order.
//  - frame_done=1 together with the out_valid of the window completed by the pixel at
//    (OFM_H-1, OFM_W-1). Otherwise frame_done=0.
//  - Back-to-back frames: the next frame's first pixel may arrive on the cycle right after
//    the last one, with no idle cycle required.
//  - Ties: a tie emits the common value. Comparison is unsigned over the full DATA_W,
//    so 8191 is a legal maximum.
//  - rst mid-frame: the partial frame is discarded and counters return to (0,0).
//    - The next in_valid is treated as pixel (0,0) of a new frame.
//    - No out_valid or frame_done is produced for the discarded frame.
//    - rst has priority over in_valid in the same cycle.
//  - No backpressure: the consumer must accept every out_valid cycle.
//  - Pixel rate: at most one pooled output per 2 input pixels, so no buffering beyond
//    the single output register is needed.
// TESTING  (bench uses OFM_W=4, OFM_H=4)
//  1. Contiguous frame, rows {1,5,2,0},{3,4,9,7},{8,8,0,1},{2,6,1,13}
//     -> out_valid 1 clk after input indices 5,7,13,15 with values 5,9,8,13.
//     frame_done only with the value 13.
//  2. Same frame with 3-cycle in_valid gaps after every pixel
//     -> identical values 5,9,8,13, each 1 clk after its completing pixel. Never extra outputs.
//  3. Window {8191,0,0,8191} and an all-equal window {7,7,7,7}
//     -> outputs 8191 and 7; no overflow or truncation.
//  4. rst asserted after input index 9, then a full frame as in 1
//     -> no output from the aborted frame; then 5,9,8,13 with a single frame_done.
//  5. Two frames back-to-back with no idle cycle, frame 2 = frame 1 + 100 per pixel
//     -> 5,9,8,13, then 105,109,108,113; two frame_done pulses.
//  6. in_valid=0 for 50 cycles after reset
//     -> out_valid, Out_Pool and frame_done stay 0.

Source files
------------

// File: rtl/ofm_maxpool_2x2.sv
// 2x2 stride-2 max pooling over a row-major OFM pixel stream.
// Half-row line buffer holds the horizontal maxima of each even row.
module ofm_maxpool_2x2 #(
  parameter int DATA_W = 13,
  parameter int OFM_W  = 8,
  parameter int OFM_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_OFM,
  output logic              out_valid,
  output logic [DATA_W-1:0] Out_Pool,
  output logic              frame_done
);

  localparam int LBW  = (OFM_W > 2) ? $clog2(OFM_W / 2) : 1;
  localparam int CW   = LBW + 1;
  localparam int RW   = (OFM_H > 2) ? $clog2(OFM_H) : 1;
  localparam int LB_N = OFM_W / 2;

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] pool_q, pool_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] lb_q [LB_N];
  logic              lb_we;
  logic [LBW-1:0]    lb_idx;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] hmax;
  logic              col_last;
  logic              row_last;

  assign lb_idx   = col_q[CW-1:1];
  assign lb_rd    = lb_q[lb_idx];
  assign col_last = (col_q == CW'(OFM_W - 1));
  assign row_last = (row_q == RW'(OFM_H - 1));
  assign hmax     = (In_OFM > prev_q) ? In_OFM : prev_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    prev_d = prev_q;
    vld_d  = 1'b0;
    pool_d = '0;
    done_d = 1'b0;
    lb_we  = 1'b0;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        prev_d = In_OFM;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        vld_d  = 1'b1;
        pool_d = (lb_rd > hmax) ? lb_rd : hmax;
        done_d = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      prev_q <= '0;
      vld_q  <= 1'b0;
      pool_q <= '0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
      pool_q <= pool_d;
      done_q <= done_d;
    end
  end

  // Contents are always written on an even row before the odd row reads them.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= hmax;
    end
  end

  assign out_valid  = vld_q;
  assign Out_Pool   = pool_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ofm_maxpool_2x2.sv
// Directed and randomized checks of ofm_maxpool_2x2 against a
// whole-frame reference model (4x4 frames).
module tb_ofm_maxpool_2x2;

  localparam int DW = 13;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] In_OFM;
  logic          out_valid;
  logic [DW-1:0] Out_Pool;
  logic          frame_done;

  int errors;
  int checks;

  int            mr, mc;
  logic [DW-1:0] pix [H][W];
  logic [DW-1:0] got [$];
  int            dones;

  typedef logic [DW-1:0] frame_t [W*H];
  frame_t f1, f2, fr;

  ofm_maxpool_2x2 #(
    .DATA_W(DW),
    .OFM_W (W),
    .OFM_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .In_OFM    (In_OFM),
    .out_valid (out_valid),
    .Out_Pool  (Out_Pool),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mx(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic outs(
    input logic          ev,
    input logic [DW-1:0] ed,
    input logic          en
  );
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("Out_Pool", 32'(Out_Pool), 32'(ed));
    chk("frame_done", 32'(frame_done), 32'(en));
    if (out_valid === 1'b1) got.push_back(Out_Pool);
    if (frame_done === 1'b1) dones++;
  endtask

  // One clock: drive, wait for the edge, then compare with the model.
  task automatic cyc(
    input logic          v,
    input logic [DW-1:0] d
  );
    logic          ev;
    logic [DW-1:0] ed;
    logic          en;
    in_valid = v;
    In_OFM   = d;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ed = '0;
    en = 1'b0;
    if (v) begin
      pix[mr][mc] = d;
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        ev = 1'b1;
        ed = mx(mx(pix[mr-1][mc-1], pix[mr-1][mc]),
                mx(pix[mr][mc-1], pix[mr][mc]));
        en = (mr == H - 1) && (mc == W - 1);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    outs(ev, ed, en);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    In_OFM   = DW'($urandom);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    mr = 0;
    mc = 0;
    outs(1'b0, '0, 1'b0);
  endtask

  task automatic send(input frame_t f, input int gap);
    for (int i = 0; i < W * H; i++) begin
      cyc(1'b1, f[i]);
      for (int g = 0; g < gap; g++) cyc(1'b0, DW'($urandom));
    end
  endtask

  task automatic expect4(
    input string       tag,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] c,
    input logic [DW-1:0] d
  );
    logic [DW-1:0] e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    chk({tag, "_count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size())
        chk(tag, 32'(got[i]), 32'(e[i]));
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    dones    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    In_OFM   = '0;
    mr = 0;
    mc = 0;
    f1 = '{1, 5, 2, 0, 3, 4, 9, 7, 8, 8, 0, 1, 2, 6, 1, 13};
    for (int i = 0; i < W * H; i++) f2[i] = f1[i] + DW'(100);

    do_reset();
    // idle after reset
    for (int i = 0; i < 50; i++) cyc(1'b0, DW'($urandom));

    // contiguous frame
    got.delete(); dones = 0;
    send(f1, 0);
    expect4("t1", 5, 9, 8, 13);
    chk("t1_done", 32'(dones), 32'd1);

    // 3-cycle gaps
    got.delete(); dones = 0;
    send(f1, 3);
    expect4("t2", 5, 9, 8, 13);
    chk("t2_done", 32'(dones), 32'd1);

    // full-scale and tie windows
    fr = f1;
    fr[0] = 8191; fr[1] = 0; fr[4] = 0; fr[5] = 8191;
    fr[2] = 7; fr[3] = 7; fr[6] = 7; fr[7] = 7;
    got.delete(); dones = 0;
    send(fr, 0);
    expect4("t3", 8191, 7, 8, 13);

    // reset after index 9, then a clean frame
    for (int i = 0; i < 10; i++) cyc(1'b1, f1[i]);
    got.delete(); dones = 0;
    do_reset();
    send(f1, 0);
    expect4("t4", 5, 9, 8, 13);
    chk("t4_done", 32'(dones), 32'd1);

    // back-to-back frames
    got.delete(); dones = 0;
    send(f1, 0);
    send(f2, 0);
    chk("t5_count", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("t5_first", 32'(got[0]), 32'd5);
      chk("t5_last", 32'(got[7]), 32'd113);
    end
    chk("t5_done", 32'(dones), 32'd2);

    // randomized frames with random gaps and extreme values
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < W * H; i++) begin
        case ($urandom_range(0, 5))
          0:       fr[i] = 8191;
          1:       fr[i] = 0;
          default: fr[i] = DW'($urandom);
        endcase
      end
      send(fr, int'($urandom_range(0, 2)));
    end

    // random mid-frame reset
    for (int i = 0; i < int'($urandom_range(1, 14)); i++)
      cyc(1'b1, DW'($urandom));
    do_reset();
    got.delete(); dones = 0;
    send(f2, 1);
    expect4("t7", 105, 109, 108, 113);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
